// File: rtl/br_credit_push_rr_arb.sv
// Credit-gated round-robin arbiter driving one registered credit/valid push port.
// Keeps the sender-side credit counter for a credit-based FIFO sink.
module br_credit_push_rr_arb #(
    parameter int NumRequesters = 2,
    parameter int Width = 1,
    parameter int MaxCredit = 2,
    localparam int CreditWidth = $clog2(MaxCredit + 1),
    localparam int IndexWidth = $clog2(NumRequesters)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumRequesters-1:0]       in_valid,
    output logic [NumRequesters-1:0]       in_ready,
    input  logic [NumRequesters*Width-1:0] in_data,
    output logic                           push_sender_in_reset,
    input  logic                           push_receiver_in_reset,
    input  logic                           push_credit,
    output logic                           push_valid,
    output logic [Width-1:0]               push_data,
    input  logic [CreditWidth-1:0]         credit_initial,
    input  logic [CreditWidth-1:0]         credit_withhold,
    output logic [CreditWidth-1:0]         credit_count,
    output logic [CreditWidth-1:0]         credit_available,
    output logic [IndexWidth-1:0]          grant_index
);

    if (NumRequesters < 2) begin : g_bad_num_requesters
        $error("NumRequesters must be at least 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("Width must be at least 1");
    end
    if (MaxCredit < 1) begin : g_bad_max_credit
        $error("MaxCredit must be at least 1");
    end

    logic                     reset_active;
    logic [CreditWidth-1:0]   count_q;
    logic [CreditWidth-1:0]   count_nxt;
    logic [IndexWidth-1:0]    ptr_q;
    logic [IndexWidth-1:0]    ptr_nxt;
    logic [NumRequesters-1:0] eligible;
    logic                     has_credit;
    logic                     grant;
    logic [IndexWidth-1:0]    win;
    logic [Width-1:0]         win_data;
    logic                     valid_q;
    logic [Width-1:0]         data_q;
    logic [IndexWidth-1:0]    index_q;
    int                       scan_idx;

    assign reset_active         = rst | push_receiver_in_reset;
    assign push_sender_in_reset = rst;

    assign credit_count     = count_q;
    assign credit_available = (count_q > credit_withhold) ?
                              count_q - credit_withhold : '0;
    assign has_credit       = |credit_available;

    // A credit returned this cycle only counts from the next cycle on.
    assign eligible = reset_active ? '0 :
                      (in_valid & {NumRequesters{has_credit}});

    always_comb begin
        grant    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int k = 0; k < NumRequesters; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NumRequesters) begin
                scan_idx = scan_idx - NumRequesters;
            end
            if (!grant && eligible[IndexWidth'(scan_idx)]) begin
                grant = 1'b1;
                win   = IndexWidth'(scan_idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NumRequesters; k++) begin
            if (win == IndexWidth'(k)) begin
                win_data = in_data[k*Width +: Width];
            end
        end
    end

    assign in_ready = grant ?
                      (NumRequesters'(1) << win) : '0;

    assign ptr_nxt = (win == IndexWidth'(NumRequesters - 1)) ?
                     '0 : win + 1'b1;

    assign count_nxt = count_q
                     + CreditWidth'(push_credit)
                     - CreditWidth'(grant);

    always_ff @(posedge clk) begin
        if (reset_active) begin
            count_q <= credit_initial;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
        end else begin
            count_q <= count_nxt;
            valid_q <= grant;
            if (grant) begin
                ptr_q   <= ptr_nxt;
                data_q  <= win_data;
                index_q <= win;
            end
        end
    end

    assign push_valid  = valid_q;
    assign push_data   = data_q;
    assign grant_index = index_q;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset_active)
        !(push_credit && !grant &&
          count_q == CreditWidth'(MaxCredit)))
        else $error("credit counter overflow");

    a_ready_onehot0: assert property (
        @(posedge clk) $onehot0(in_ready))
        else $error("in_ready not onehot0");

    a_initial_legal: assert property (
        @(posedge clk) reset_active |->
        (credit_initial <= CreditWidth'(MaxCredit)))
        else $error("credit_initial exceeds MaxCredit");

    c_count_zero: cover property (
        @(posedge clk) !reset_active && count_q == '0);
    c_count_max: cover property (
        @(posedge clk) !reset_active &&
        count_q == CreditWidth'(MaxCredit));
    c_credit_with_grant: cover property (
        @(posedge clk) grant && push_credit);
    c_wrap: cover property (
        @(posedge clk) grant && win < ptr_q);

    for (genvar g = 0; g < NumRequesters; g++) begin : g_cov
        c_granted: cover property (
            @(posedge clk) grant && win == IndexWidth'(g));
    end

endmodule

// File: tb/tb_br_credit_push_rr_arb.sv
// Table-driven bench for br_credit_push_rr_arb (4 requesters, MaxCredit 4)
// with a scoreboard of expected pushes.
module tb_br_credit_push_rr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           push_sender_in_reset;
    logic           push_receiver_in_reset;
    logic           push_credit;
    logic           push_valid;
    logic [W-1:0]   push_data;
    logic [2:0]     credit_initial;
    logic [2:0]     credit_withhold;
    logic [2:0]     credit_count;
    logic [2:0]     credit_available;
    logic [1:0]     grant_index;

    br_credit_push_rr_arb #(
        .NumRequesters(N),
        .Width(W),
        .MaxCredit(MC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .push_sender_in_reset(push_sender_in_reset),
        .push_receiver_in_reset(push_receiver_in_reset),
        .push_credit(push_credit),
        .push_valid(push_valid),
        .push_data(push_data),
        .credit_initial(credit_initial),
        .credit_withhold(credit_withhold),
        .credit_count(credit_count),
        .credit_available(credit_available),
        .grant_index(grant_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rrst;
        logic [3:0] valid;
        logic       credit;
        logic [2:0] wh;
        logic [2:0] ci;
        logic [3:0] ready;
        logic [2:0] cnt;
        logic [2:0] avail;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
    } push_t;

    vec_t  tv[$];
    push_t sb[$];
    int    errors = 0;
    int    checks = 0;

    task automatic add(input logic r, input logic rr,
                       input logic [3:0] v, input logic c,
                       input logic [2:0] wh, input logic [2:0] ci,
                       input logic [3:0] rdy, input logic [2:0] cnt,
                       input logic [2:0] av);
        vec_t e;
        e = '{r, rr, v, c, wh, ci, rdy, cnt, av};
        tv.push_back(e);
    endtask

    task automatic chk(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, step, act, exp);
        end
    endtask

    function automatic logic [7:0] dval(input int i, input int s);
        return 8'((i + 1) * 16 + (s % 16));
    endfunction

    initial begin
        logic       prev_grant;
        logic [7:0] last_data;
        logic [1:0] last_idx;
        push_t      e;
        vec_t       v;

        add(1,0,4'hF,0,0,2,4'h0,2,2);
        add(0,0,4'hF,0,0,2,4'h1,2,2);
        add(0,0,4'hF,0,0,2,4'h2,1,1);
        add(0,0,4'hF,0,0,2,4'h0,0,0);
        add(0,0,4'hF,0,0,2,4'h0,0,0);
        add(0,0,4'h8,1,0,2,4'h0,0,0);
        add(0,0,4'h8,0,0,2,4'h8,1,1);
        add(0,0,4'h8,0,0,2,4'h0,0,0);
        add(1,0,4'h0,0,0,4,4'h0,0,0);
        add(0,0,4'h6,1,0,4,4'h2,4,4);
        add(0,0,4'h6,1,0,4,4'h4,4,4);
        add(0,0,4'h6,1,0,4,4'h2,4,4);
        add(0,0,4'h6,1,0,4,4'h4,4,4);
        add(0,0,4'h0,0,0,4,4'h0,4,4);
        add(0,0,4'h1,0,0,4,4'h1,4,4);
        add(0,0,4'hF,0,3,4,4'h0,3,0);
        add(0,0,4'hF,0,3,4,4'h0,3,0);
        add(0,0,4'hF,0,1,4,4'h2,3,2);
        add(0,0,4'hF,0,1,4,4'h4,2,1);
        add(0,0,4'hF,0,1,4,4'h0,1,0);
        add(0,0,4'h8,1,0,3,4'h8,1,1);
        add(0,1,4'hF,1,0,3,4'h0,1,1);
        add(0,1,4'hF,1,0,3,4'h0,3,3);
        add(0,0,4'hF,0,0,3,4'h1,3,3);
        add(0,0,4'h0,0,0,3,4'h0,2,2);
        add(0,0,4'h4,0,0,3,4'h4,2,2);
        add(0,0,4'h4,0,0,3,4'h4,1,1);
        add(0,0,4'h0,0,0,3,4'h0,0,0);
        add(0,0,4'h0,0,0,3,4'h0,0,0);

        rst = 1'b1;
        push_receiver_in_reset = 1'b0;
        push_credit = 1'b0;
        in_valid = '0;
        in_data = '0;
        credit_initial = 3'd2;
        credit_withhold = 3'd0;
        repeat (2) @(negedge clk);

        prev_grant = 1'b0;
        last_data  = '0;
        last_idx   = '0;

        for (int s = 0; s < tv.size(); s++) begin
            v = tv[s];
            rst = v.rst;
            push_receiver_in_reset = v.rrst;
            in_valid = v.valid;
            push_credit = v.credit;
            credit_withhold = v.wh;
            credit_initial = v.ci;
            for (int i = 0; i < N; i++) begin
                in_data[i*W +: W] = dval(i, s);
            end
            #1;
            chk("push_valid", s, 32'(push_valid), 32'(prev_grant));
            if (prev_grant) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", s, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("push_data", s, 32'(push_data), 32'(e.data));
                    chk("grant_index", s, 32'(grant_index), 32'(e.idx));
                    last_data = e.data;
                    last_idx  = e.idx;
                end
            end else begin
                chk("data_hold", s, 32'(push_data), 32'(last_data));
                chk("index_hold", s, 32'(grant_index), 32'(last_idx));
            end
            chk("in_ready", s, 32'(in_ready), 32'(v.ready));
            chk("credit_count", s, 32'(credit_count), 32'(v.cnt));
            chk("credit_available", s, 32'(credit_available),
                32'(v.avail));
            chk("sender_in_reset", s, 32'(push_sender_in_reset),
                32'(v.rst));
            prev_grant = |v.ready;
            for (int i = 0; i < N; i++) begin
                if (v.ready[i]) begin
                    e.data = dval(i, s);
                    e.idx  = 2'(i);
                    sb.push_back(e);
                end
            end
            if (v.rst || v.rrst) begin
                last_data = '0;
                last_idx  = '0;
            end
            @(negedge clk);
        end

        in_valid = '0;
        push_credit = 1'b0;
        #1;
        chk("final_push_valid", tv.size(), 32'(push_valid), 32'd0);
        chk("sb_drained", tv.size(), 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/br_credit_push_rr_arb.md
Name: br_credit_push_rr_arb

Overview:
- Single-clock arbiter that shares one credit/valid push interface among NumRequesters ready/valid requesters.
- Typical sink is the push side of a credit-based CDC FIFO controller.
- Keeps the sender-side credit counter, applies round-robin arbitration gated by credit availability, and drives a registered push_valid/push_data.
- Runs entirely in the push clock domain.

Parameters:
- NumRequesters, 2, number of requesters; must be at least 2.
- Width, 1, data width per requester; must be at least 1.
- MaxCredit, 2, maximum credit count; must be at least 1.
- CreditWidth, $clog2(MaxCredit+1), localparam, credit counter width.
- IndexWidth, $clog2(NumRequesters), localparam, grant index width.

Ports:
- clk  input  1  posedge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  NumRequesters  per-requester valid.
- in_ready  output  NumRequesters  per-requester ready (one-hot grant).
- in_data  input  NumRequesters*Width  packed requester data; requester i occupies bits [i*Width +: Width].
- push_sender_in_reset  output  1  tells the receiver the sender is in reset.
- push_receiver_in_reset  input  1  receiver is in reset.
- push_credit  input  1  one credit returned by the receiver.
- push_valid  output  1  registered push valid.
- push_data  output  Width  registered push data.
- credit_initial  input  CreditWidth  credit value loaded during reset; must be at most MaxCredit.
- credit_withhold  input  CreditWidth  credits held back from use.
- credit_count  output  CreditWidth  current credit counter.
- credit_available  output  CreditWidth  usable credits, computed as count minus withhold, floored at 0.
- grant_index  output  IndexWidth  index of the last granted requester (registered).

Behaviour:
- Reset is active while rst=1 or push_receiver_in_reset=1. While reset is active:
  - credit_count loads credit_initial.
  - push_valid=0, push_data=0, grant_index=0, in_ready=0.
  - Priority pointer is set to 0; push_credit is ignored.
- push_sender_in_reset = rst, combinational, with no path from push_receiver_in_reset.
- credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : 0. It is combinational from current state and inputs.
- Eligibility: requester i is eligible when in_valid[i]=1 and credit_available != 0. A credit returned this cycle does not bypass into the grant decision.
- Round-robin selection:
  - Scan starts at the priority pointer and wraps modulo NumRequesters; the first eligible requester wins.
  - in_ready is one-hot on the winner and all-zero when no requester is eligible.
  - A transfer occurs when in_valid[i] and in_ready[i] are both 1.
- Pointer update: after a grant to index g, the pointer becomes (g+1) mod NumRequesters. With no grant, the pointer holds.
- Output register:
  - On a grant, next cycle push_valid=1, push_data=winner's in_data and grant_index=g.
  - Otherwise next cycle push_valid=0; push_data and grant_index hold.
  - Latency from transfer to push_valid is exactly 1 cycle.
- Credit counter next value:
  - count + push_credit - grant.
  - A simultaneous credit return and grant leaves the count unchanged.
  - The counter never goes negative, because a grant requires credit_available ≥ 1.
- Throughput: one transfer per cycle while credits last; no bubble is inserted between consecutive grants.
- in_ready is a combinational function of in_valid, state and credit_withhold. Requesters may drop valid without a handshake; the arbiter does not require valid to be held stable.
- credit_withhold may change at any cycle. If it is raised above credit_count, grants stop and no state is corrupted.
- Assertions:
  - push_credit=1 while credit_count==MaxCredit with no grant that cycle (overflow) is an error.
  - in_ready has at most one bit set (onehot0).
  - credit_initial ≤ MaxCredit during reset.
  - Parameter legality is checked at elaboration.
- Coverage: credit_count reaches 0 and MaxCredit; credit return coincides with a grant; every requester is granted; pointer wrap-around occurs.
- Final check: push_valid=0 at end of test.

Test Plan:
- Reset with credit_initial=2, all in_valid=1 (N=4) -> in_ready 0001 then 0010; push_valid high 2 cycles with requester 0 then requester 1 data; credit_count 2→1→0; in_ready=0 afterwards.
- credit_count=0, one push_credit pulse with requester 3 valid -> grant in the cycle after the credit; push_valid one cycle later carrying requester 3 data; credit_count 1→0.
- MaxCredit=4, credit_initial=4, continuous valid on requesters 1 and 2 with a push_credit every cycle -> alternating 1,2,1,2 grants; credit_count steady at 4; push_valid held at 1.
- credit_count=3 with credit_withhold=3 -> credit_available=0 and no grants; lower withhold to 1 -> credit_available=2; exactly 2 grants then stall.
- push_receiver_in_reset asserted mid-stream with credit_count=1 -> next cycle push_valid=0, credit_count=credit_initial, pointer=0; push_credit during reset ignored; traffic resumes after deassert.
- Only requester 2 valid while pointer=3 -> wrap-around grant to 2; pointer becomes 3; grant_index=2.
